// File: rtl/verificador_comparador.sv
// verificador_comparador
//   Scoreboard-style checker for a K-bit unsigned magnitude comparator.
//   Operands are captured when valid_in is high in IDLE. The expected one-hot
//   result {gt,lt,eq} is computed at capture time. The checker then waits for
//   dut_done, latches {mayor,menor,igual} and scores the result on the
//   following cycle.
//
//   Optional feature (macro CHECKER_TIMEOUT_EN):
//     When defined, the module adds the output timeout_flag and a WAIT-cycle
//     counter. A check that stays in WAIT for TIMEOUT cycles without dut_done
//     is scored as a failure.
//     When undefined, WAIT holds until dut_done or reset.
//
// Ports
//   clk           : clock; all state changes on its rising edge
//   reset_L       : asynchronous reset, active low
//   A_valor       : operand A (K bits)
//   B_valor       : operand B (K bits)
//   valid_in      : operands are valid this cycle
//   mayor         : comparator DUT flag "greater than"
//   menor         : comparator DUT flag "less than"
//   igual         : comparator DUT flag "equal"
//   dut_done      : DUT flags are valid this cycle
//   busy          : a check is in progress
//   check_done    : one-cycle pulse when a check completes
//   pass_count    : checks passed, saturating at 255
//   fail_count    : checks failed, saturating at 255
//   error         : sticky; set on any failure
//   overrun       : sticky; set when valid_in arrives while busy
//   timeout_flag  : sticky; set on a WAIT timeout (CHECKER_TIMEOUT_EN only)

module verificador_comparador #(
  parameter int unsigned K       = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic [K-1:0] A_valor,
  input  logic [K-1:0] B_valor,
  input  logic         valid_in,
  input  logic         mayor,
  input  logic         menor,
  input  logic         igual,
  input  logic         dut_done,
  output logic         busy,
  output logic         check_done,
  output logic [7:0]   pass_count,
  output logic [7:0]   fail_count,
  output logic         error,
  output logic         overrun
`ifdef CHECKER_TIMEOUT_EN
  ,
  output logic         timeout_flag
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t     state;

  // The operands themselves are only needed to form the expected result.
  // Storing that 3-bit result at capture time replaces storing A and B.
  logic [2:0] exp_q;    // {gt, lt, eq}
  logic [2:0] flags_q;  // {mayor, menor, igual}

`ifdef CHECKER_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state        <= IDLE;
      busy         <= 1'b0;
      check_done   <= 1'b0;
      pass_count   <= '0;
      fail_count   <= '0;
      error        <= 1'b0;
      overrun      <= 1'b0;
      exp_q        <= '0;
      flags_q      <= '0;
`ifdef CHECKER_TIMEOUT_EN
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      check_done <= 1'b0;

      case (state)
        IDLE: begin
          // dut_done is ignored here, even when it coincides with valid_in.
          if (valid_in) begin
            exp_q <= {A_valor > B_valor, A_valor < B_valor, A_valor == B_valor};
            state <= WAIT;
            busy  <= 1'b1;
`ifdef CHECKER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end

        WAIT: begin
          if (valid_in) overrun <= 1'b1;
          if (dut_done) begin
            flags_q <= {mayor, menor, igual};
            state   <= CHECK;
`ifdef CHECKER_TIMEOUT_EN
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th WAIT edge without dut_done.
            // A dut_done arriving on this same edge takes the branch above.
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            error        <= 1'b1;
            timeout_flag <= 1'b1;
            check_done   <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
`endif
          end
        end

        CHECK: begin
          if (valid_in) overrun <= 1'b1;
          // An exact match against a one-hot expectation also rejects a
          // DUT result with no flag set or with several flags set.
          if (flags_q == exp_q) begin
            if (pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
          end else begin
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
            error <= 1'b1;
          end
          check_done <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
